bb_v0_ctl: RTL and testbench
============================

BB_V0_CTL -- requirements
Module: bb_v0_ctl

Interface
REQ-001 SHALL have parameter CLEAR_ON_RESET, default 1: when 1, zero-fill all 16 SRAM words after reset release.
REQ-002 SHALL have port v_clk, input, 1: single clock shared with the v0 SRAM macro.
REQ-003 SHALL have port reset_l, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 1: access request, sampled on the v_clk rising edge.
REQ-005 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-006 SHALL have port req_addr, input, [15:2]: word address.
REQ-007 SHALL have port req_len, input, [1:0]: read burst length minus 1 (1..4 words); ignored on writes.
REQ-008 SHALL have port req_wdata, input, [31:0]: write data, sampled with the request.
REQ-009 SHALL have port req_ack, output, 1: one-cycle pulse marking the request accepted.
REQ-010 SHALL have port busy, output, 1: high during CLEAR or ACCESS, and while read beats are in flight.
REQ-011 SHALL have port rd_valid, output, 1: rd_data holds one read beat.
REQ-012 SHALL have port rd_data, output, [31:0]: registered read data.
REQ-013 SHALL have port v_me, output, 1: SRAM enable.
REQ-014 SHALL have port v_we, output, 1: SRAM write enable.
REQ-015 SHALL have port v_addr, output, [15:2]: SRAM address.
REQ-016 SHALL have port v_in, output, [31:0]: SRAM write data.
REQ-017 SHALL have port v_out, input, [31:0]: SRAM read data, valid in the cycle after the v_me cycle.

Function
REQ-018 SHALL implement FSM states CLEAR, IDLE and ACCESS; every output SHALL be driven directly from a flop.
REQ-019 SHALL accept a request only in IDLE with req=1; req SHALL be ignored in CLEAR and ACCESS, and the requester SHALL hold req until it sees req_ack.
REQ-020 On acceptance edge E0, SHALL enter ACCESS; in cycle E0..E1 drive v_me=1, v_addr=req_addr, v_we=req_we, v_in=req_wdata and req_ack=1.
REQ-021 A write SHALL be exactly one beat; the FSM SHALL return to IDLE at E1 and a new request SHALL be acceptable at E1.
REQ-022 A read SHALL issue req_len+1 consecutive v_me cycles with v_we=0.
REQ-023 Each read beat SHALL increment v_addr[5:2] by 1, wrapping 15 to 0; v_addr[15:6] SHALL be held.
REQ-024 After the last read beat, the FSM SHALL return to IDLE.
REQ-025 For the beat driven in cycle k, SHALL sample v_out at the end of cycle k+1 and present rd_data with rd_valid=1 during cycle k+2.
REQ-026 Beats SHALL be returned in order, with no gaps within a burst.
REQ-027 rd_valid SHALL be 0 in every cycle with no beat to present.
REQ-028 Outside ACCESS and CLEAR, SHALL hold v_me=0, v_we=0, v_addr and v_in at their last values, and req_ack=0.
REQ-029 busy SHALL be 1 in CLEAR, in ACCESS, and until the last rd_valid of a burst; back-to-back accepts SHALL still be allowed when busy is due only to in-flight read beats.
REQ-030 CLEAR, entered after reset release when CLEAR_ON_RESET=1: SHALL drive v_me=1, v_we=1, v_in=0 and v_addr[5:2]=0..15 over 16 consecutive cycles with v_addr[15:6]=0, then go to IDLE.
REQ-031 When CLEAR_ON_RESET=0, the FSM SHALL start in IDLE.
REQ-032 A read of the address written in the previous cycle SHALL return the new data: the SRAM commits the write on the falling edge, and no interlock is required.

Reset
REQ-033 reset_l=0 SHALL asynchronously force v_me=0, v_we=0, req_ack=0, rd_valid=0, v_addr=0, v_in=0 and rd_data=0.
REQ-034 reset_l=0 SHALL asynchronously clear the in-flight read pipeline and the beat counters.
REQ-035 During reset, busy SHALL be 1 when CLEAR_ON_RESET=1, and 0 otherwise.
REQ-036 Reset asserted mid-burst or mid-clear SHALL abandon the operation and produce no further rd_valid.
REQ-037 On the first edge after reset release, the FSM SHALL enter CLEAR (CLEAR_ON_RESET=1) or IDLE (CLEAR_ON_RESET=0).

Verification
REQ-038 Release reset with CLEAR_ON_RESET=1, then read 4 words at addr 0x0: 16 write cycles occur with v_in=0, busy falls, and 4 beats return 0x00000000.
REQ-039 Write 0xDEADBEEF to word 0x3, then read req_len=0 on the next edge: v_me is high in two consecutive cycles and rd_data=0xDEADBEEF exactly two cycles after the read v_me cycle.
REQ-040 Read req_len=3 at word 0xE with upper bits 0x100: v_addr[5:2] sequence is E,F,0,1, v_addr[15:6] stays 0x100, and 4 contiguous rd_valid pulses occur.
REQ-041 Hold req=1 during CLEAR: no req_ack until CLEAR ends, then exactly one req_ack.
REQ-042 Assert reset_l=0 at the second beat of a 4-beat read: all outputs are 0 immediately, no rd_valid follows, and CLEAR restarts after release.

Source files
------------

// File: rtl/bb_v0_ctl.sv
// Request controller for the 16-word v0 SRAM macro: single-beat writes, 1..4 word
// wrapping read bursts with a two-cycle return pipeline, and optional zero-fill after reset.
module bb_v0_ctl #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        v_clk,
    input  logic        reset_l,
    input  logic        req,
    input  logic        req_we,
    input  logic [15:2] req_addr,
    input  logic [1:0]  req_len,
    input  logic [31:0] req_wdata,
    output logic        req_ack,
    output logic        busy,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        v_me,
    output logic        v_we,
    output logic [15:2] v_addr,
    output logic [31:0] v_in,
    input  logic [31:0] v_out
);

    localparam logic [1:0] ST_CLEAR  = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        clr_pend_q, clr_pend_d;
    logic [3:0]  clr_cnt_q, clr_cnt_d;
    logic [1:0]  beats_q, beats_d;
    logic        v_me_q, v_me_d;
    logic        v_we_q, v_we_d;
    logic [15:2] v_addr_q, v_addr_d;
    logic [31:0] v_in_q, v_in_d;
    logic        req_ack_q, req_ack_d;
    logic        rd_pend_q, rd_pend_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        busy_q, busy_d;
    logic        accept;
    logic [3:0]  nxt_word;

    assign nxt_word = v_addr_q[5:2] + 4'd1;

    always_comb begin
        state_d    = state_q;
        clr_pend_d = clr_pend_q;
        clr_cnt_d  = clr_cnt_q;
        beats_d    = beats_q;
        v_me_d     = 1'b0;
        v_we_d     = 1'b0;
        v_addr_d   = v_addr_q;
        v_in_d     = v_in_q;
        req_ack_d  = 1'b0;
        accept     = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == 4'hF) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 4'd1;
                    v_me_d    = 1'b1;
                    v_we_d    = 1'b1;
                    v_in_d    = '0;
                    v_addr_d  = {10'd0, clr_cnt_d};
                end
            end
            ST_ACCESS: begin
                if (beats_q != 2'd0) begin
                    beats_d  = beats_q - 2'd1;
                    v_me_d   = 1'b1;
                    v_addr_d = {v_addr_q[15:6], nxt_word};
                end else begin
                    // The edge ending the last beat is already idle, so a waiting request goes straight in.
                    accept = 1'b1;
                end
            end
            default: accept = 1'b1;
        endcase

        if (accept) begin
            if (clr_pend_q) begin
                clr_pend_d = 1'b0;
                state_d    = ST_CLEAR;
                clr_cnt_d  = 4'd0;
                v_me_d     = 1'b1;
                v_we_d     = 1'b1;
                v_in_d     = '0;
                v_addr_d   = '0;
            end else if (req) begin
                state_d   = ST_ACCESS;
                v_me_d    = 1'b1;
                v_we_d    = req_we;
                v_addr_d  = req_addr;
                v_in_d    = req_wdata;
                req_ack_d = 1'b1;
                beats_d   = req_we ? 2'd0 : req_len;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Read return pipeline: SRAM data appears one cycle after the beat and is registered once more.
    always_comb begin
        rd_pend_d  = v_me_q & ~v_we_q;
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_pend_q ? v_out : rd_data_q;
        busy_d     = v_me_d | rd_pend_d | rd_valid_d;
    end

    always_ff @(posedge v_clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= ST_IDLE;
            clr_pend_q <= CLEAR_ON_RESET;
            clr_cnt_q  <= 4'd0;
            beats_q    <= 2'd0;
            v_me_q     <= 1'b0;
            v_we_q     <= 1'b0;
            v_addr_q   <= '0;
            v_in_q     <= '0;
            req_ack_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            busy_q     <= CLEAR_ON_RESET;
        end else begin
            state_q    <= state_d;
            clr_pend_q <= clr_pend_d;
            clr_cnt_q  <= clr_cnt_d;
            beats_q    <= beats_d;
            v_me_q     <= v_me_d;
            v_we_q     <= v_we_d;
            v_addr_q   <= v_addr_d;
            v_in_q     <= v_in_d;
            req_ack_q  <= req_ack_d;
            rd_pend_q  <= rd_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            busy_q     <= busy_d;
        end
    end

    assign req_ack  = req_ack_q;
    assign busy     = busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign v_me     = v_me_q;
    assign v_we     = v_we_q;
    assign v_addr   = v_addr_q;
    assign v_in     = v_in_q;

endmodule

// File: tb/tb_bb_v0_ctl.sv
// Self-checking bench for bb_v0_ctl: behavioural 16-word SRAM, read-data scoreboard,
// and a per-cycle trace of the SRAM-side outputs for timing checks.
module tb_bb_v0_ctl;

    logic        v_clk = 1'b0;
    logic        reset_l;
    logic        req;
    logic        req_we;
    logic [15:2] req_addr;
    logic [1:0]  req_len;
    logic [31:0] req_wdata;
    logic        req_ack;
    logic        busy;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        v_me;
    logic        v_we;
    logic [15:2] v_addr;
    logic [31:0] v_in;
    logic [31:0] v_out;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [0:15];
    logic [31:0] sram [0:15];

    logic        tr_me   [0:4095];
    logic        tr_we   [0:4095];
    logic        tr_rv   [0:4095];
    logic [15:2] tr_addr [0:4095];
    logic [31:0] tr_rd   [0:4095];

    always #5 v_clk = ~v_clk;

    bb_v0_ctl dut (
        .v_clk     (v_clk),
        .reset_l   (reset_l),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .busy      (busy),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .v_me      (v_me),
        .v_we      (v_we),
        .v_addr    (v_addr),
        .v_in      (v_in),
        .v_out     (v_out)
    );

    // SRAM model: write commits on the falling edge, read data registered on the rising edge.
    initial begin
        for (int i = 0; i < 16; i++) sram[i] = 32'hA5A5_0000 + 32'(i);
        v_out = 32'd0;
    end
    always @(negedge v_clk) if (v_me && v_we) sram[v_addr[5:2]] <= v_in;
    always @(posedge v_clk) if (v_me && !v_we) v_out <= sram[v_addr[5:2]];

    initial forever begin
        @(posedge v_clk);
        cyc++;
    end

    initial forever begin
        @(negedge v_clk);
        if (cyc < 4096) begin
            tr_me[cyc]   = v_me;
            tr_we[cyc]   = v_we;
            tr_rv[cyc]   = rd_valid;
            tr_addr[cyc] = v_addr;
            tr_rd[cyc]   = rd_data;
        end
        if (rd_valid === 1'b1) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL rd_valid_unexpected: rd_valid=1 data=%h, required no beat", rd_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) $display("FAIL rd_data: got %h required %h", rd_data, e);
                else pass_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue_req(input logic we, input logic [15:2] addr, input logic [1:0] len,
                             input logic [31:0] data, output int acc_cyc);
        int n;
        logic [3:0] w;
        n = 0;
        req = 1'b1; req_we = we; req_addr = addr; req_len = len; req_wdata = data;
        do begin
            @(posedge v_clk); #1; n++;
        end while (req_ack !== 1'b1 && n < 100);
        req = 1'b0;
        acc_cyc = cyc;
        total_cnt++;
        if (req_ack !== 1'b1) begin
            $display("FAIL req_ack_timeout: ack=%b after %0d cycles, required 1", req_ack, n);
        end else begin
            pass_cnt++;
            $display("txn %s addr=%h len=%0d data=%h accepted in cycle %0d",
                     we ? "WR" : "RD", addr, len, data, acc_cyc);
            if (we) ref_mem[addr[5:2]] = data;
            else for (int i = 0; i <= int'(len); i++) begin
                w = addr[5:2] + i[3:0];
                exp_q.push_back(ref_mem[w]);
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge v_clk); n++;
        end while ((busy !== 1'b0 || exp_q.size() != 0) && n < 60);
        total_cnt++;
        if (busy !== 1'b0 || exp_q.size() != 0)
            $display("FAIL %s_drain: busy=%b pending=%0d, required busy=0 pending=0", tag, busy, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic release_and_clear(input string tag);
        int n_clr, n_bad, n_rv;
        n_clr = 0; n_bad = 0; n_rv = 0;
        @(posedge v_clk); #1;
        reset_l = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge v_clk);
            if (v_me && v_we) begin
                if (v_in !== 32'd0 || v_addr !== {10'd0, n_clr[3:0]}) n_bad++;
                n_clr++;
            end
            if (rd_valid) n_rv++;
            if (busy === 1'b0) break;
        end
        total_cnt++;
        if (n_clr != 16) $display("FAIL %s_clear_count: got %0d write cycles, required 16", tag, n_clr);
        else pass_cnt++;
        total_cnt++;
        if (n_bad != 0) $display("FAIL %s_clear_pattern: got %0d bad cycles, required 0", tag, n_bad);
        else pass_cnt++;
        total_cnt++;
        if (n_rv != 0 || busy !== 1'b0)
            $display("FAIL %s_clear_end: rd_valid cycles=%0d busy=%b, required 0 and 0", tag, n_rv, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset_l = 1'b0; req = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0; req_wdata = '0;
        repeat (3) @(negedge v_clk);
        total_cnt++; if (v_me !== 1'b0) $display("FAIL reset_v_me: got %b required 0", v_me); else pass_cnt++;
        total_cnt++; if (v_we !== 1'b0) $display("FAIL reset_v_we: got %b required 0", v_we); else pass_cnt++;
        total_cnt++; if (req_ack !== 1'b0) $display("FAIL reset_req_ack: got %b required 0", req_ack); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b required 0", rd_valid); else pass_cnt++;
        total_cnt++; if (v_addr !== 14'd0) $display("FAIL reset_v_addr: got %h required 0", v_addr); else pass_cnt++;
        total_cnt++; if (v_in !== 32'd0) $display("FAIL reset_v_in: got %h required 0", v_in); else pass_cnt++;
        total_cnt++; if (rd_data !== 32'd0) $display("FAIL reset_rd_data: got %h required 0", rd_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b required 1", busy); else pass_cnt++;
    endtask

    task automatic test_clear_read();
        int c;
        release_and_clear("boot");
        issue_req(1'b0, 14'h0, 2'd3, 32'd0, c);
        wait_idle("clear_read");
    endtask

    task automatic test_raw();
        int c0, c1;
        issue_req(1'b1, 14'h3, 2'd0, 32'hDEAD_BEEF, c0);
        issue_req(1'b0, 14'h3, 2'd0, 32'd0, c1);
        wait_idle("raw");
        total_cnt++;
        if (c1 != c0 + 1) $display("FAIL raw_b2b_accept: read cycle %0d, required %0d", c1, c0 + 1);
        else pass_cnt++;
        total_cnt++;
        if ({tr_me[c0], tr_we[c0], tr_me[c0+1], tr_we[c0+1]} !== 4'b1110)
            $display("FAIL raw_vme: me/we pair %b%b %b%b, required 11 10",
                     tr_me[c0], tr_we[c0], tr_me[c0+1], tr_we[c0+1]);
        else pass_cnt++;
        total_cnt++;
        if (tr_rv[c0+2] !== 1'b0 || tr_rv[c0+3] !== 1'b1 || tr_rd[c0+3] !== 32'hDEAD_BEEF)
            $display("FAIL raw_latency: rv=%b%b data=%h, required rv=01 data=deadbeef",
                     tr_rv[c0+2], tr_rv[c0+3], tr_rd[c0+3]);
        else pass_cnt++;
        total_cnt++;
        if (tr_me[c0+2] !== 1'b0 || tr_addr[c0+2] !== 14'h3)
            $display("FAIL raw_addr_hold: v_me=%b v_addr=%h, required 0 and 0003", tr_me[c0+2], tr_addr[c0+2]);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int c;
        logic [3:0] w;
        logic [5:0] rv;
        for (int i = 0; i < 4; i++) begin
            w = 4'hE + i[3:0];
            issue_req(1'b1, {10'h100, w}, 2'd0, 32'hC0DE_0000 + 32'(i), c);
        end
        issue_req(1'b0, {10'h100, 4'hE}, 2'd3, 32'd0, c);
        wait_idle("wrap");
        for (int i = 0; i < 4; i++) begin
            w = 4'hE + i[3:0];
            total_cnt++;
            if (tr_me[c+i] !== 1'b1 || tr_we[c+i] !== 1'b0 || tr_addr[c+i] !== {10'h100, w})
                $display("FAIL wrap_beat%0d: v_me=%b v_we=%b v_addr=%h, required 1 0 %h",
                         i, tr_me[c+i], tr_we[c+i], tr_addr[c+i], {10'h100, w});
            else pass_cnt++;
        end
        total_cnt++;
        if (tr_me[c+4] !== 1'b0) $display("FAIL wrap_end: v_me=%b after 4 beats, required 0", tr_me[c+4]);
        else pass_cnt++;
        rv = {tr_rv[c+1], tr_rv[c+2], tr_rv[c+3], tr_rv[c+4], tr_rv[c+5], tr_rv[c+6]};
        total_cnt++;
        if (rv !== 6'b011110) $display("FAIL wrap_rd_valid: pattern %b, required 011110", rv);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int c, c1, c2, c3, c4;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            issue_req(1'b1, 14'(6 + i), 2'd0, d, c);
        end
        issue_req(1'b0, 14'h6, 2'd1, 32'd0, c1);
        issue_req(1'b0, 14'h9, 2'd0, 32'd0, c2);
        issue_req(1'b0, 14'h7, 2'd3, 32'd0, c3);
        issue_req(1'b1, 14'hA, 2'd0, 32'h5555_AAAA, c4);
        issue_req(1'b0, 14'hA, 2'd0, 32'd0, c);
        wait_idle("b2b");
        total_cnt++;
        if (c2 != c1 + 2 || c3 != c2 + 1)
            $display("FAIL b2b_read_accept: cycles %0d %0d %0d, required gaps 2 and 1", c1, c2, c3);
        else pass_cnt++;
        total_cnt++;
        if (c4 != c3 + 4) $display("FAIL b2b_write_after_burst: cycle %0d, required %0d", c4, c3 + 4);
        else pass_cnt++;
    endtask

    task automatic test_clear_hold();
        int acks, n_clr, c;
        acks = 0; n_clr = 0;
        @(posedge v_clk); #1;
        reset_l = 1'b0;
        exp_q.delete();
        req = 1'b1; req_we = 1'b1; req_addr = 14'h5; req_len = 2'd0; req_wdata = 32'h1234_5678;
        repeat (2) @(posedge v_clk);
        #1;
        reset_l = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
        for (int i = 0; i < 60; i++) begin
            @(negedge v_clk);
            if (req_ack === 1'b1) begin
                acks++;
                req = 1'b0;
            end else if (acks == 0 && v_me && v_we && v_in == 32'd0) begin
                n_clr++;
            end
        end
        total_cnt++;
        if (acks != 1) $display("FAIL hold_ack_count: got %0d acks, required 1", acks);
        else pass_cnt++;
        total_cnt++;
        if (n_clr != 16) $display("FAIL hold_clear_first: got %0d clear cycles before ack, required 16", n_clr);
        else pass_cnt++;
        if (acks == 1) ref_mem[5] = 32'h1234_5678;
        issue_req(1'b0, 14'h5, 2'd0, 32'd0, c);
        wait_idle("hold");
    endtask

    task automatic test_reset_midburst();
        int c, n_rv;
        n_rv = 0;
        issue_req(1'b0, 14'h0, 2'd3, 32'hFFFF_0000, c);
        @(posedge v_clk); #2;
        reset_l = 1'b0;
        exp_q.delete();
        #1;
        total_cnt++;
        if ({v_me, v_we, req_ack, rd_valid} !== 4'b0000 || v_addr !== 14'd0 || v_in !== 32'd0 || rd_data !== 32'd0)
            $display("FAIL midburst_outputs: me=%b we=%b ack=%b rv=%b addr=%h in=%h rd=%h, required all 0",
                     v_me, v_we, req_ack, rd_valid, v_addr, v_in, rd_data);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL midburst_busy: got %b required 1", busy);
        else pass_cnt++;
        repeat (3) begin
            @(negedge v_clk);
            if (rd_valid !== 1'b0) n_rv++;
        end
        total_cnt++;
        if (n_rv != 0) $display("FAIL midburst_no_rd_valid: got %0d beats, required 0", n_rv);
        else pass_cnt++;
        release_and_clear("midburst");
        issue_req(1'b0, 14'h0, 2'd3, 32'd0, c);
        wait_idle("midburst");
    endtask

    initial begin
        test_reset();
        test_clear_read();
        test_raw();
        test_wrap();
        test_back_to_back();
        test_clear_hold();
        test_reset_midburst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
